// File: rtl/utils_pkg.sv
// Shared datapath helpers: sign/zero extenders, LSU access size and byte-enable mask.
// Pure types and functions; no latency and no flow control.
package utils_pkg;

  localparam int DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    LSU_B = 2'b00,
    LSU_H = 2'b01,
    LSU_W = 2'b10,
    LSU_D = 2'b11
  } lsu_size_e;

  function automatic logic [63:0] sext_8(input logic [7:0] v);
    return {{56{v[7]}}, v};
  endfunction

  function automatic logic [63:0] zext_8(input logic [7:0] v);
    return {56'b0, v};
  endfunction

  function automatic logic [63:0] sext_16(input logic [15:0] v);
    return {{48{v[15]}}, v};
  endfunction

  function automatic logic [63:0] zext_16(input logic [15:0] v);
    return {48'b0, v};
  endfunction

  function automatic logic [63:0] sext_32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] zext_32(input logic [31:0] v);
    return {32'b0, v};
  endfunction

  // Lanes past byte 7 are dropped; only aligned accesses ever reach memory.
  function automatic logic [7:0] be_mask(input lsu_size_e size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      LSU_B:   m = 8'h01;
      LSU_H:   m = 8'h03;
      LSU_W:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: shifts the addressed lane of a doubleword down and sign/zero extends it.
// Combinational, zero latency; no flow control.
module lsu_load_align
  import utils_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_off,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_data
);

  logic [63:0] w_sh;

  assign w_sh = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = w_sh;
    case (i_size)
      LSU_B:   o_data = i_unsigned ? zext_8(w_sh[7:0])   : sext_8(w_sh[7:0]);
      LSU_H:   o_data = i_unsigned ? zext_16(w_sh[15:0]) : sext_16(w_sh[15:0]);
      LSU_W:   o_data = i_unsigned ? zext_32(w_sh[31:0]) : sext_32(w_sh[31:0]);
      default: o_data = w_sh;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store sequencer: accept -> mem req/gnt -> rvalid -> one-cycle resp (min 4 cycles, misaligned 2).
// req_ready is low from accept until the response cycle has passed; mem_* held stable until mem_gnt.
module lsu_ctrl
  import utils_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [4:0]            resp_rd,
  output logic                  resp_misalign,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_be,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

  lsu_state_e            r_state, w_state_nxt;
  logic                  r_we, w_we_nxt;
  lsu_size_e             r_size, w_size_nxt;
  logic                  r_uns, w_uns_nxt;
  logic [2:0]            r_off, w_off_nxt;
  logic [4:0]            r_rd, w_rd_nxt;
  logic                  r_mem_req, w_mem_req_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [7:0]            r_mem_be, w_mem_be_nxt;
  logic                  r_resp_valid, w_resp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_resp_data, w_resp_data_nxt;
  logic [4:0]            r_resp_rd, w_resp_rd_nxt;
  logic                  r_resp_mis, w_resp_mis_nxt;

  lsu_size_e             w_req_size;
  logic                  w_misalign;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_req_size = lsu_size_e'(req_size);

  always_comb begin
    w_misalign = 1'b0;
    case (w_req_size)
      LSU_H:   w_misalign = req_addr[0];
      LSU_W:   w_misalign = |req_addr[1:0];
      LSU_D:   w_misalign = |req_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  lsu_load_align u_load_align (
    .i_rdata    (mem_rdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_load)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_we_nxt         = r_we;
    w_size_nxt       = r_size;
    w_uns_nxt        = r_uns;
    w_off_nxt        = r_off;
    w_rd_nxt         = r_rd;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_be_nxt     = r_mem_be;
    w_resp_valid_nxt = 1'b0;
    w_resp_data_nxt  = r_resp_data;
    w_resp_rd_nxt    = r_resp_rd;
    w_resp_mis_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_we_nxt   = req_we;
          w_size_nxt = w_req_size;
          w_uns_nxt  = req_unsigned;
          w_off_nxt  = req_addr[2:0];
          w_rd_nxt   = req_rd;
          if (w_misalign) begin
            w_state_nxt      = RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_mis_nxt   = 1'b1;
            w_resp_data_nxt  = '0;
            w_resp_rd_nxt    = req_rd;
          end else begin
            w_state_nxt     = REQ;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = req_we;
            w_mem_addr_nxt  = {req_addr[ADDR_WIDTH-1:3], 3'b000};
            w_mem_wdata_nxt = req_wdata << {req_addr[2:0], 3'b000};
            w_mem_be_nxt    = be_mask(w_req_size, req_addr[2:0]);
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          w_state_nxt   = WAIT;
          w_mem_req_nxt = 1'b0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt      = RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_data_nxt  = r_we ? '0 : w_load;
          w_resp_rd_nxt    = r_rd;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= LSU_B;
      r_uns        <= 1'b0;
      r_off        <= '0;
      r_rd         <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_rd    <= '0;
      r_resp_mis   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_we         <= w_we_nxt;
      r_size       <= w_size_nxt;
      r_uns        <= w_uns_nxt;
      r_off        <= w_off_nxt;
      r_rd         <= w_rd_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_be     <= w_mem_be_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_resp_rd    <= w_resp_rd_nxt;
      r_resp_mis   <= w_resp_mis_nxt;
    end
  end

  assign req_ready     = (r_state == IDLE);
  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign resp_rd       = r_resp_rd;
  assign resp_misalign = r_resp_mis;
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_be        = r_mem_be;

  // Stray rvalid outside WAIT is legal after a reset (stale ack), so it is flagged, not treated as an error.
  cover property (@(posedge clk) disable iff (!rst_n) mem_rvalid && (r_state != WAIT));

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: hand-computed loads, stores, misalignment, stall, reset and back-to-back cases.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_misalign;
  logic [63:0] resp_data;
  logic [4:0]  resp_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_misalign(resp_misalign),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_rd = rd;
  endtask

  task automatic accept(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    int n;
    set_req(we, sz, uns, addr, wd, rd);
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic rvalid(input logic [63:0] d);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [63:0] d, input logic [4:0] rd, input logic mis);
    check({tag, "_rvld"}, resp_valid, 1'b1);
    check({tag, "_data"}, resp_data, d);
    check({tag, "_rd"}, resp_rd, rd);
    check({tag, "_mis"}, resp_misalign, mis);
    check({tag, "_rdy_in_resp"}, req_ready, 1'b0);
    tick();
    check({tag, "_rvld_drop"}, resp_valid, 1'b0);
    check({tag, "_rdy_back"}, req_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_req;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    check("rst_ready", req_ready, 1'b1);
    check("rst_rvld", resp_valid, 1'b0);
    check("rst_mis", resp_misalign, 1'b0);
    check("rst_mreq", mem_req, 1'b0);
    check("rst_mwe", mem_we, 1'b0);
    check("rst_maddr", mem_addr, 64'h0);
    check("rst_mbe", {56'b0, mem_be}, 64'h0);
    check("rst_rdata", resp_data, 64'h0);

    // LB 0x1003, minimal latency; LBU queued during the response cycle.
    accept("lb", 1'b0, 2'b00, 1'b0, 64'h1003, 64'h0, 5'd5);
    check("lb_mreq", mem_req, 1'b1);
    check("lb_maddr", mem_addr, 64'h1000);
    check("lb_mbe", {56'b0, mem_be}, 64'h08);
    check("lb_mwe", mem_we, 1'b0);
    check("lb_rdy_busy", req_ready, 1'b0);
    grant();
    check("lb_mreq_drop", mem_req, 1'b0);
    check("lb_rvld_wait", resp_valid, 1'b0);
    rvalid(64'h0000_0000_8000_0000);
    check("lb_rvld", resp_valid, 1'b1);
    check("lb_data", resp_data, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_rd", resp_rd, 5'd5);
    check("lb_mis", resp_misalign, 1'b0);
    set_req(1'b0, 2'b00, 1'b1, 64'h1003, 64'h0, 5'd6);
    check("b2b_rdy_in_resp", req_ready, 1'b0);
    tick();
    check("b2b_rvld_drop", resp_valid, 1'b0);
    check("b2b_rdy_idle", req_ready, 1'b1);
    check("b2b_no_early_req", mem_req, 1'b0);
    tick();
    req_valid = 1'b0;
    check("lbu_mreq", mem_req, 1'b1);
    grant();
    rvalid(64'h0000_0000_8000_0000);
    check_resp("lbu", 64'h80, 5'd6, 1'b0);

    // LW 0x2002: misaligned, answered next cycle with no memory access.
    accept("lw_mis", 1'b0, 2'b10, 1'b0, 64'h2002, 64'h0, 5'd9);
    seen_req = mem_req;
    check_resp("lw_mis", 64'h0, 5'd9, 1'b1);
    seen_req = seen_req | mem_req;
    tick();
    seen_req = seen_req | mem_req;
    check("lw_mis_no_mreq", seen_req, 1'b0);

    // SH 0x1006: lane steering to bytes 6..7.
    accept("sh", 1'b1, 2'b01, 1'b0, 64'h1006, 64'h0000_0000_1234_ABCD, 5'd3);
    check("sh_maddr", mem_addr, 64'h1000);
    check("sh_mbe", {56'b0, mem_be}, 64'hC0);
    check("sh_mwdata", mem_wdata, 64'hABCD_0000_0000_0000);
    check("sh_mwe", mem_we, 1'b1);
    grant();
    rvalid(64'hDEAD_BEEF_DEAD_BEEF);
    check_resp("sh", 64'h0, 5'd3, 1'b0);

    // LD 0x3008 with grant withheld five cycles.
    accept("ld", 1'b0, 2'b11, 1'b0, 64'h3008, 64'h0, 5'd12);
    for (int i = 0; i < 5; i++) begin
      check("ld_stall_mreq", mem_req, 1'b1);
      check("ld_stall_maddr", mem_addr, 64'h3008);
      check("ld_stall_mbe", {56'b0, mem_be}, 64'hFF);
      check("ld_stall_mwe", mem_we, 1'b0);
      tick();
    end
    grant();
    tick();
    check("ld_rvld_early", resp_valid, 1'b0);
    rvalid(64'h0123_4567_89AB_CDEF);
    check_resp("ld", 64'h0123_4567_89AB_CDEF, 5'd12, 1'b0);

    // LH 0x6002: halfword at offset 2, sign bit set.
    accept("lh", 1'b0, 2'b01, 1'b0, 64'h6002, 64'h0, 5'd14);
    check("lh_mbe", {56'b0, mem_be}, 64'h0C);
    grant();
    rvalid(64'h0000_0000_8001_0000);
    check_resp("lh", 64'hFFFF_FFFF_FFFF_8001, 5'd14, 1'b0);

    // Reset while waiting for rvalid; the late ack must be ignored.
    accept("rst_op", 1'b0, 2'b01, 1'b0, 64'h4002, 64'h0, 5'd7);
    grant();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_mreq", mem_req, 1'b0);
    check("midrst_rvld", resp_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    rvalid(64'h0000_0000_FFFF_0000);
    check("stale_rvld", resp_valid, 1'b0);
    check("stale_ready", req_ready, 1'b1);
    tick();
    check("stale_rvld2", resp_valid, 1'b0);

    accept("lwu", 1'b0, 2'b10, 1'b1, 64'h5000, 64'h0, 5'd20);
    check("lwu_mbe", {56'b0, mem_be}, 64'h0F);
    grant();
    rvalid(64'hFFFF_FFFF_8000_0000);
    check_resp("lwu", 64'h0000_0000_8000_0000, 5'd20, 1'b0);

    accept("lw", 1'b0, 2'b10, 1'b0, 64'h5004, 64'h0, 5'd21);
    check("lw_mbe", {56'b0, mem_be}, 64'hF0);
    check("lw_maddr", mem_addr, 64'h5000);
    grant();
    rvalid(64'h8000_0000_1234_5678);
    check_resp("lw", 64'hFFFF_FFFF_8000_0000, 5'd21, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
